// File: rtl/aes_ctrl_pkg.sv
// Shared types and widths for the AES core controller and its arbiter.
package aes_ctrl_pkg;

  localparam int AES_KEY_W = 128;
  localparam int AES_BLK_W = 128;
  localparam int NUM_REQ   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEYINIT = 3'd1,
    KEYWAIT = 3'd2,
    START   = 3'd3,
    BUSY    = 3'd4,
    RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/aes_ctrl_rr_arb.sv
// Two-way round-robin grant; a tie goes to the requester that did not win last.
module aes_ctrl_rr_arb
  import aes_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic               valid_o,
  output logic               id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = 1'b0;
    if (req_i == 2'b11) begin
      id_o = ~last_i;
    end else if (req_i[1]) begin
      id_o = 1'b1;
    end
  end

endmodule

// File: rtl/aes_ctrl.sv
// Arbitrates two requesters onto one AES core, caching the expanded key and
// bounding key expansion and block processing with a timeout.
module aes_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic                         clock,
  input  logic                         resetb,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_dec,
  input  logic [NUM_REQ*AES_KEY_W-1:0] req_key,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_block,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [AES_BLK_W-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic                         core_init,
  output logic                         core_next,
  output logic                         core_dec,
  output logic [AES_KEY_W-1:0]         core_key,
  output logic [AES_BLK_W-1:0]         core_block,
  input  logic                         core_ready,
  input  logic [AES_BLK_W-1:0]         core_result,
  input  logic                         core_result_valid,
  output logic                         busy,
  output logic                         grant_id
);

  state_t               state_q;
  logic [15:0]          cnt_q;
  logic                 key_loaded_q;
  logic [AES_KEY_W-1:0] cache_key_q;
  logic                 last_grant_q;
  logic                 grant_q;
  logic                 core_init_q;
  logic                 core_next_q;
  logic                 core_dec_q;
  logic [AES_KEY_W-1:0] core_key_q;
  logic [AES_BLK_W-1:0] core_block_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [AES_BLK_W-1:0] rsp_data_q;
  logic                 rsp_err_q;

  logic                 gnt_valid;
  logic                 gnt_id;
  logic [AES_KEY_W-1:0] sel_key;
  logic [AES_BLK_W-1:0] sel_block;
  logic                 key_hit;
  logic                 timeout_hit;

  aes_ctrl_rr_arb u_arb (
    .req_i   (req_valid),
    .last_i  (last_grant_q),
    .valid_o (gnt_valid),
    .id_o    (gnt_id)
  );

  assign sel_key     = gnt_id ? req_key[AES_KEY_W +: AES_KEY_W] : req_key[0 +: AES_KEY_W];
  assign sel_block   = gnt_id ? req_block[AES_BLK_W +: AES_BLK_W] : req_block[0 +: AES_BLK_W];
  assign key_hit     = KEY_CACHE && key_loaded_q && (sel_key == cache_key_q);
  assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

  // Ready is gated by reset so every output reads zero while resetb is low.
  assign req_ready  = (resetb && state_q == IDLE && gnt_valid) ? {gnt_id, ~gnt_id} : 2'b00;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign core_init  = core_init_q;
  assign core_next  = core_next_q;
  assign core_dec   = core_dec_q;
  assign core_key   = core_key_q;
  assign core_block = core_block_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_loaded_q <= 1'b0;
      cache_key_q  <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      core_init_q  <= 1'b0;
      core_next_q  <= 1'b0;
      core_dec_q   <= 1'b0;
      core_key_q   <= '0;
      core_block_q <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            core_key_q   <= sel_key;
            core_block_q <= sel_block;
            core_dec_q   <= req_dec[gnt_id];
            grant_q      <= gnt_id;
            if (key_hit) begin
              core_next_q <= 1'b1;
              state_q     <= START;
            end else begin
              core_init_q <= 1'b1;
              state_q     <= KEYINIT;
            end
          end
        end
        KEYINIT: begin
          cnt_q   <= '0;
          state_q <= KEYWAIT;
        end
        KEYWAIT: begin
          if (core_ready) begin
            cache_key_q  <= core_key_q;
            key_loaded_q <= 1'b1;
            core_next_q  <= 1'b1;
            state_q      <= START;
          end else if (timeout_hit) begin
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b1;
            key_loaded_q <= 1'b0;
            rsp_valid_q  <= {grant_q, ~grant_q};
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          if (core_result_valid) begin
            rsp_data_q  <= core_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= {grant_q, ~grant_q};
            state_q     <= RESP;
          end else if (timeout_hit) begin
            // A hung core may have lost its key schedule, so force re-expansion.
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b1;
            key_loaded_q <= 1'b0;
            rsp_valid_q  <= {grant_q, ~grant_q};
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q  <= '0;
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctrl.sv
// Directed scoreboard bench for aes_ctrl against a small behavioural AES core model.
module tb_aes_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B    = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] BLK_B    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] BLK_C    = 128'hdeadbeefcafef00d1234567890abcdef;

  typedef struct {
    logic         id;
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic         clock;
  logic         resetb;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_dec;
  logic [255:0] req_key;
  logic [255:0] req_block;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         core_init;
  logic         core_next;
  logic         core_dec;
  logic [127:0] core_key;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_result;
  logic         core_result_valid;
  logic         busy;
  logic         grant_id;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   failures = 0;
  int   cycleNum = 0;
  int   initCount = 0;
  int   nextCount = 0;
  int   overlapCount = 0;
  int   acceptOutside = 0;
  int   lastNextCycle = 0;
  int   respCycle = 0;
  bit   hangMode = 1'b0;
  bit   spurious = 1'b0;

  int           expCnt;
  int           resCnt;
  logic [127:0] resKey;
  logic [127:0] resBlk;
  logic         resDec;

  aes_ctrl #(.TIMEOUT(16), .KEY_CACHE(1'b1)) dut (
    .clock             (clock),
    .resetb            (resetb),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_dec           (req_dec),
    .req_key           (req_key),
    .req_block         (req_block),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_err           (rsp_err),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_dec          (core_dec),
    .core_key          (core_key),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_result       (core_result),
    .core_result_valid (core_result_valid),
    .busy              (busy),
    .grant_id          (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [1:0] oneHot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  // Stand-in for the cipher: the FIPS-197 vector is exact, anything else is a cheap mix.
  function automatic logic [127:0] coreFn(input logic [127:0] k, input logic [127:0] b, input logic d);
    if (!d && k == FIPS_KEY && b == FIPS_PT) return FIPS_CT;
    return {b[63:0], b[127:64]} ^ k ^ {128{d}};
  endfunction

  // Core model: key expansion takes 3 cycles with ready low, a block takes 4 cycles.
  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      core_ready        <= 1'b1;
      core_result_valid <= 1'b0;
      core_result       <= '0;
      expCnt            <= 0;
      resCnt            <= 0;
      resKey            <= '0;
      resBlk            <= '0;
      resDec            <= 1'b0;
    end else begin
      core_result_valid <= 1'b0;
      if (core_init) begin
        core_ready <= 1'b0;
        expCnt     <= 3;
      end else if (expCnt != 0) begin
        expCnt <= expCnt - 1;
        if (expCnt == 1) core_ready <= 1'b1;
      end
      if (core_next) begin
        resCnt <= 4;
        resKey <= core_key;
        resBlk <= core_block;
        resDec <= core_dec;
      end else if (resCnt != 0) begin
        resCnt <= resCnt - 1;
        if (resCnt == 1 && !hangMode) begin
          core_result_valid <= 1'b1;
          core_result       <= coreFn(resKey, resBlk, resDec);
        end
      end
      if (spurious) begin
        core_result_valid <= 1'b1;
        core_result       <= '1;
      end
    end
  end

  always @(posedge clock) cycleNum++;

  always @(negedge clock) begin
    if (core_init) initCount++;
    if (core_next) begin
      nextCount++;
      lastNextCycle = cycleNum;
    end
    if (core_init && core_next) overlapCount++;
    if (busy && (req_ready != 2'b00)) acceptOutside++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request, waits for the handshake and checks the strobe in the following cycle.
  task automatic applyStimulus(input logic id, input logic dec, input logic [127:0] key,
                               input logic [127:0] blk, input logic expMiss, input logic expTimeout);
    exp_t e;
    int   w;
    int   idx;
    idx = id ? 128 : 0;
    @(negedge clock);
    req_key[idx +: 128]   = key;
    req_block[idx +: 128] = blk;
    req_dec[id]           = dec;
    req_valid[id]         = 1'b1;
    #1;
    w = 0;
    while (!req_ready[id] && w < 200) begin
      @(negedge clock);
      #1;
      w++;
    end
    checkOutput("req_accept_wait", 128'(w < 200), 128'(1));
    e.id   = id;
    e.data = expTimeout ? 128'h0 : coreFn(key, blk, dec);
    e.err  = expTimeout;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    req_valid[id] = 1'b0;
    checkOutput("core_init_after_hs", 128'(core_init), 128'(expMiss));
    checkOutput("core_next_after_hs", 128'(core_next), 128'(!expMiss));
  endtask

  // Waits for the response, optionally stalls rsp_ready, then pops and compares.
  task automatic waitResponse(input int stall);
    exp_t e;
    int   w;
    w = 0;
    while (rsp_valid == 2'b00 && w < 300) begin
      @(negedge clock);
      w++;
    end
    checkOutput("rsp_wait", 128'(w < 300), 128'(1));
    if (w >= 300 || sb.size() == 0) return;
    respCycle = cycleNum;
    e = sb.pop_front();
    checkOutput("rsp_valid", 128'(rsp_valid), 128'(oneHot(e.id)));
    checkOutput("grant_id", 128'(grant_id), 128'(e.id));
    checkOutput("rsp_data", rsp_data, e.data);
    checkOutput("rsp_err", 128'(rsp_err), 128'(e.err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      checkOutput("stall_rsp_valid", 128'(rsp_valid), 128'(oneHot(e.id)));
      checkOutput("stall_rsp_data", rsp_data, e.data);
      checkOutput("stall_req_ready", 128'(req_ready), 128'(0));
      checkOutput("stall_busy", 128'(busy), 128'(1));
    end
    rsp_ready = oneHot(e.id);
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 2'b00;
    checkOutput("rsp_released", 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    int i0;
    int n0;
    int seen;
    exp_t e;
    resetb    = 1'b0;
    req_valid = 2'b11;
    req_dec   = 2'b00;
    req_key   = '0;
    req_block = '0;
    rsp_ready = 2'b00;
    repeat (3) @(negedge clock);
    checkOutput("reset_req_ready", 128'(req_ready), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    req_valid = 2'b00;
    resetb    = 1'b1;

    $display("[TB] FIPS-197 vector with cold key cache");
    i0 = initCount; n0 = nextCount;
    applyStimulus(1'b0, 1'b0, FIPS_KEY, FIPS_PT, 1'b1, 1'b0);
    waitResponse(0);
    checkOutput("s1_init_pulses", 128'(initCount - i0), 128'(1));
    checkOutput("s1_next_pulses", 128'(nextCount - n0), 128'(1));

    $display("[TB] same key reuses cached expansion");
    i0 = initCount;
    applyStimulus(1'b0, 1'b0, FIPS_KEY, BLK_B, 1'b0, 1'b0);
    waitResponse(0);
    checkOutput("s2_no_init", 128'(initCount - i0), 128'(0));

    $display("[TB] response held while rsp_ready stalls");
    applyStimulus(1'b0, 1'b1, FIPS_KEY, BLK_C, 1'b0, 1'b0);
    waitResponse(5);

    $display("[TB] hung core times out");
    hangMode = 1'b1;
    applyStimulus(1'b0, 1'b0, FIPS_KEY, BLK_B, 1'b0, 1'b1);
    waitResponse(0);
    checkOutput("timeout_busy_cycles", 128'(respCycle - lastNextCycle - 1), 128'(16));
    hangMode = 1'b0;
    applyStimulus(1'b0, 1'b0, FIPS_KEY, BLK_B, 1'b1, 1'b0);
    waitResponse(0);

    $display("[TB] reset during BUSY");
    applyStimulus(1'b1, 1'b0, FIPS_KEY, BLK_C, 1'b0, 1'b0);
    @(negedge clock);
    #2 resetb = 1'b0;
    #1;
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_grant_id", 128'(grant_id), 128'(0));
    checkOutput("abort_core_key", core_key, 128'(0));
    checkOutput("abort_rsp_data", rsp_data, 128'(0));
    checkOutput("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    sb.delete();
    @(negedge clock);
    resetb = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (rsp_valid != 2'b00) seen++;
    end
    checkOutput("abort_no_rsp", 128'(seen), 128'(0));
    applyStimulus(1'b1, 1'b0, FIPS_KEY, BLK_C, 1'b1, 1'b0);
    waitResponse(0);

    $display("[TB] round-robin with both requesters held");
    @(negedge clock);
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    req_key   = {KEY_B, FIPS_KEY};
    req_block = {BLK_B, FIPS_PT};
    req_dec   = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      #1;
      while (req_ready == 2'b00 && seen < 200) begin
        @(negedge clock);
        #1;
        seen++;
      end
      e.id   = k[0];
      e.data = k[0] ? coreFn(KEY_B, BLK_B, 1'b0) : FIPS_CT;
      e.err  = 1'b0;
      checkOutput("rr_req_ready", 128'(req_ready), 128'(oneHot(e.id)));
      sb.push_back(e);
      @(posedge clock);
      @(negedge clock);
      waitResponse(0);
    end
    req_valid = 2'b00;

    $display("[TB] stray result_valid while idle");
    @(negedge clock);
    spurious = 1'b1;
    @(posedge clock);
    #1 spurious = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (rsp_valid != 2'b00 || busy) seen++;
    end
    checkOutput("stray_ignored", 128'(seen), 128'(0));
    applyStimulus(1'b0, 1'b0, FIPS_KEY, BLK_C, 1'b1, 1'b0);
    waitResponse(0);

    checkOutput("init_next_overlap", 128'(overlapCount), 128'(0));
    checkOutput("accept_outside_idle", 128'(acceptOutside), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aes_ctrl.md
AES_CTRL -- requirements
Module: aes_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024, SHALL set the maximum cycles allowed in KEYWAIT or BUSY before an error response.
REQ-002 Parameter KEY_CACHE, default 1, SHALL enable skipping key expansion when the key is unchanged.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be (name, direction, width, meaning):
clock  in  1  system clock
resetb  in  1  asynchronous active-low reset
req_valid  in  2  request valid, one bit per requester
req_ready  out  2  request accept, one bit per requester
req_dec  in  2  1=decrypt, 0=encrypt, per requester
req_key  in  256  requester i key at [128*i+127:128*i]
req_block  in  256  requester i block at [128*i+127:128*i]
rsp_valid  out  2  response valid, one-hot to owning requester
rsp_ready  in  2  response accept, per requester
rsp_data  out  128  result block
rsp_err  out  1  timeout flag, qualified by rsp_valid
core_init  out  1  one-cycle key-expansion strobe to AES core
core_next  out  1  one-cycle block-start strobe to AES core
core_dec  out  1  mode to AES core
core_key  out  128  key to AES core
core_block  out  128  block to AES core
core_ready  in  1  core idle / key expansion complete
core_result  in  128  core output block
core_result_valid  in  1  core_result valid
busy  out  1  state != IDLE
grant_id  out  1  requester currently owning the core

Function
REQ-005 FSM states SHALL be IDLE, KEYINIT, KEYWAIT, START, BUSY, RESP.
REQ-006 Arbitration (IDLE only): round-robin on req_valid; both valid -> the requester not last granted; req_ready[grant] high combinationally in IDLE; a request withdrawn before handshake is legal and re-arbitrated each cycle.
REQ-007 On handshake: latch key, block, dec, and id into registers driving core_key, core_block, core_dec, grant_id.
REQ-008 Next state after handshake: START if KEY_CACHE=1, key_loaded=1, and latched key equals cached key; else KEYINIT.
REQ-009 Latency: handshake at edge T -> core_init (miss) or core_next (hit) high for exactly the cycle after T.
REQ-010 KEYINIT: core_init high one cycle -> KEYWAIT.
REQ-011 KEYWAIT: first sample of core_ready is the cycle after the core_init strobe; on core_ready=1, store cached key, set key_loaded -> START.
REQ-012 START: core_next high one cycle -> BUSY.
REQ-013 BUSY: on core_result_valid, register core_result into rsp_data, rsp_err=0 -> RESP.
REQ-014 Timeout: a 16-bit counter cleared on entry to KEYWAIT and to BUSY; reaching TIMEOUT-1 without completion -> rsp_data=0, rsp_err=1, key_loaded=0 -> RESP.
REQ-015 RESP: rsp_valid[grant_id] held high with rsp_data and rsp_err stable until rsp_ready[grant_id]; then -> IDLE, last_grant=grant_id.
REQ-016 core_init and core_next SHALL never be high in the same cycle; no request is accepted outside IDLE.
REQ-017 core_result_valid outside BUSY SHALL be ignored.

Reset
REQ-018 resetb low SHALL asynchronously force: state IDLE, all outputs 0, key_loaded 0, counter 0, last_grant 1 (requester 0 wins first).
REQ-019 Reset during any non-IDLE state SHALL abort the operation with no response issued.

Structure
REQ-020 Shared package aes_ctrl_pkg SHALL hold the state encoding, AES_KEY_W=128, AES_BLK_W=128, and NUM_REQ=2.
REQ-021 Sub-module aes_ctrl_rr_arb SHALL implement the 2-way round-robin grant; all other logic lives in aes_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- req0 encrypt, key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> one core_init, one core_next, rsp_valid[0] with data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
- Second req0 with the same key -> no core_init; core_next in the cycle after the handshake.
- After reset, req_valid=2'b11 held -> grants in order 0,1,0,1; grant_id matches each response.
- Core model never asserts result_valid, TIMEOUT=16 -> rsp_err=1 and rsp_data=0 after 16 BUSY cycles; the next same-key request issues core_init.
- rsp_ready[0] low for 5 cycles -> rsp_valid[0] and rsp_data stable, req_ready=0, busy=1 throughout.
- resetb low during BUSY -> outputs 0 immediately, no rsp_valid; the next request issues core_init.
